// File: rtl/fifo_axi_drain.sv
// Drains a small FIFO into a circular memory region as AXI4 INCR write bursts.
// Each W beat is popped, registered and then presented, so a beat takes at least three cycles.
module fifo_axi_drain #(
  parameter int                DATA_W       = 16,
  parameter int                CNT_W        = 3,
  parameter int                BURST_LEN    = 4,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                REGION_BYTES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [CNT_W-1:0]      fifo_count_i,
  input  logic [DATA_W-1:0]     fifo_dout_i,
  output logic                  fifo_rd_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           bursts_done_o
);

  localparam int              BYTES         = DATA_W / 8;
  localparam int              BURST_BYTES   = BURST_LEN * BYTES;
  localparam logic [2:0]      SIZE          = 3'($clog2(BYTES));
  localparam logic [31:0]     BURST_LEN_U   = 32'(BURST_LEN);
  localparam logic [ADDR_W:0] BURST_BYTES_X = (ADDR_W+1)'(BURST_BYTES);
  localparam logic [ADDR_W:0] REGION_X      = (ADDR_W+1)'(REGION_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    POP,
    LOAD,
    DATA,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [8:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wlast_q, wlast_d;
  logic                err_q, err_d;
  logic [15:0]         burstsDone_q, burstsDone_d;

  logic [31:0]         countExt;
  logic                startFull;
  logic                startFlush;
  logic [8:0]          startLen;
  logic [ADDR_W-1:0]   nextOffset;
  logic [ADDR_W:0]     nextEnd;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      offset_q     <= '0;
      awaddr_q     <= BASE_ADDR;
      awlen_q      <= '0;
      wdata_q      <= '0;
      wlast_q      <= 1'b0;
      err_q        <= 1'b0;
      burstsDone_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      offset_q     <= offset_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      wdata_q      <= wdata_d;
      wlast_q      <= wlast_d;
      err_q        <= err_d;
      burstsDone_q <= burstsDone_d;
    end
  end

  // A flush burst is capped at BURST_LEN so the room reserved before the region end always suffices.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    offset_d     = offset_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    wdata_d      = wdata_q;
    wlast_d      = wlast_q;
    err_d        = err_q;
    burstsDone_d = burstsDone_q;

    countExt   = 32'(fifo_count_i);
    startFull  = enable_i && (countExt >= BURST_LEN_U);
    startFlush = flush_i && !fifo_empty_i;
    startLen   = (countExt >= BURST_LEN_U) ? 9'(BURST_LEN) : 9'(countExt);
    nextOffset = offset_q + ADDR_W'(32'(len_q) * 32'(BYTES));
    nextEnd    = {1'b0, nextOffset} + BURST_BYTES_X;

    case (state_q)
      IDLE: begin
        if (startFull || startFlush) begin
          len_d    = startLen;
          awlen_d  = 8'(startLen - 9'd1);
          awaddr_d = BASE_ADDR + offset_q;
          beat_d   = '0;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (awready_i) begin
          state_d = POP;
        end
      end
      POP: begin
        if (!fifo_empty_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        wdata_d = fifo_dout_i;
        wlast_d = (9'(beat_q) == len_q - 9'd1);
        state_d = DATA;
      end
      DATA: begin
        if (wready_i) begin
          beat_d  = beat_q + 8'd1;
          state_d = wlast_q ? RESP : POP;
        end
      end
      RESP: begin
        if (bvalid_i) begin
          err_d        = err_q | (bresp_i != 2'b00);
          burstsDone_d = burstsDone_q + 16'd1;
          offset_d     = (nextEnd > REGION_X) ? '0 : nextOffset;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The pop strobe is gated by reset so no word is pulled during the cycle the burst is abandoned.
  assign fifo_rd_o     = rstn_i && (state_q == POP) && !fifo_empty_i;
  assign awaddr_o      = awaddr_q;
  assign awlen_o       = awlen_q;
  assign awsize_o      = SIZE;
  assign awburst_o     = 2'b01;
  assign awvalid_o     = (state_q == ADDR);
  assign wdata_o       = wdata_q;
  assign wstrb_o       = '1;
  assign wlast_o       = wlast_q;
  assign wvalid_o      = (state_q == DATA);
  assign bready_o      = (state_q == RESP);
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;
  assign bursts_done_o = burstsDone_q;

endmodule

// File: tb/tb_fifo_axi_drain.sv
// Bench for fifo_axi_drain: a transaction-level model (FIFO queue, popped-word queue, region offset)
// checked every cycle, plus a table of start decisions and directed multi-cycle sequences.
module tb_fifo_axi_drain;

  localparam int          DATA_W       = 16;
  localparam int          CNT_W        = 3;
  localparam int          BURST_LEN    = 4;
  localparam int          ADDR_W       = 32;
  localparam logic [31:0] BASE_ADDR    = 32'h0000_1000;
  localparam int          REGION_BYTES = 16;
  localparam int          BYTES        = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                enable = 1'b0;
  logic                flush = 1'b0;
  logic                fifoEmpty = 1'b1;
  logic [CNT_W-1:0]    fifoCount = '0;
  logic [DATA_W-1:0]   fifoDout = '0;
  logic                fifoRd;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready = 1'b1;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready = 1'b1;
  logic [1:0]          bresp = 2'b00;
  logic                bvalid = 1'b1;
  logic                bready;
  logic                busy;
  logic                err;
  logic [15:0]         burstsDone;

  always #5 clk = ~clk;

  fifo_axi_drain #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR), .REGION_BYTES(REGION_BYTES)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .flush_i(flush),
    .fifo_empty_i(fifoEmpty), .fifo_count_i(fifoCount), .fifo_dout_i(fifoDout), .fifo_rd_o(fifoRd),
    .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .busy_o(busy), .err_o(err), .bursts_done_o(burstsDone)
  );

  typedef struct {
    bit en;
    bit fl;
    int cnt;
    bit expStart;
    int expAwlen;
  } vec_t;

  vec_t vecs[7];

  logic [DATA_W-1:0] fifoQ[$];
  logic [DATA_W-1:0] poppedQ[$];
  logic [ADDR_W-1:0] awLog[$];
  logic [DATA_W-1:0] wLog[$];
  logic              wlastLog[$];

  int nChecks = 0;
  int nErrors = 0;
  int nPops = 0;
  int mBusy = 0, mAwPending = 0, mLen = 0, mBeats = 0, mPops = 0, mOffset = 0, mBursts = 0;
  bit mErr = 1'b0;
  bit checkResetNext = 1'b0, checkDoneNext = 1'b0;
  bit randomReady = 1'b0, fillRandom = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic syncFifo();
    fifoCount = CNT_W'(fifoQ.size());
    fifoEmpty = (fifoQ.size() == 0);
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] w);
    fifoQ.push_back(w);
    syncFifo();
  endtask

  task automatic applyStimulus(input bit en, input bit fl, input bit awr, input bit wr, input bit bv, input logic [1:0] br);
    enable  = en;
    flush   = fl;
    awready = awr;
    wready  = wr;
    bvalid  = bv;
    bresp   = br;
  endtask

  // One clock: sample at the falling edge, compare against the model, advance the model, then
  // update the FIFO model just after the rising edge.
  task automatic tick();
    bit popNow;
    int nextOff;
    if (randomReady) begin
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      bvalid  = ($urandom_range(0, 2) != 0);
      bresp   = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
    end
    @(negedge clk);
    if (checkResetNext) begin
      checkOutput("resetAwaddr", awaddr, BASE_ADDR);
      checkOutput("resetAwlen", awlen, 0);
      checkOutput("resetWdata", wdata, 0);
      checkOutput("resetFlags", {wlast, err, awvalid, wvalid, bready}, 0);
      checkOutput("resetBurstsDone", burstsDone, 0);
      checkResetNext = 1'b0;
    end
    if (checkDoneNext) begin
      checkOutput("burstsDone", burstsDone, mBursts);
      checkOutput("errSticky", err, mErr);
      checkDoneNext = 1'b0;
    end
    checkOutput("busy", busy, mBusy);
    popNow = fifoRd && (fifoQ.size() > 0);
    if (fifoRd) nPops++;
    if (!rstn) begin
      mBusy = 0; mAwPending = 0; mBeats = 0; mPops = 0; mOffset = 0; mBursts = 0; mErr = 1'b0;
      poppedQ.delete();
      checkResetNext = 1'b1;
    end else if (mBusy == 0) begin
      checkOutput("idleQuiet", {fifoRd, awvalid, wvalid, bready}, 0);
      if ((enable && fifoCount >= BURST_LEN) || (flush && !fifoEmpty)) begin
        mLen = (enable && fifoCount >= BURST_LEN) ? BURST_LEN : int'(fifoCount);
        mBusy = 1; mAwPending = 1; mBeats = 0; mPops = 0;
        poppedQ.delete();
      end
    end else begin
      checkOutput("awvalid", awvalid, mAwPending);
      if (mAwPending != 0) begin
        checkOutput("awaddr", awaddr, BASE_ADDR + mOffset);
        checkOutput("awlen", awlen, mLen - 1);
        if (awready && awvalid) begin
          awLog.push_back(awaddr);
          mAwPending = 0;
        end
      end
      if (fifoRd) begin
        checkOutput("rdWhileEmpty", fifoEmpty, 0);
        checkOutput("rdOrder", (mAwPending == 0 && poppedQ.size() == 0 && mPops < mLen), 1);
        mPops++;
        if (popNow) poppedQ.push_back(fifoQ[0]);
      end
      checkOutput("breadyEarly", bready && (mBeats != mLen), 0);
      checkOutput("wvalidNoWord", wvalid && (poppedQ.size() == 0), 0);
      if (wvalid && poppedQ.size() > 0) begin
        checkOutput("wdata", wdata, poppedQ[0]);
        checkOutput("wlast", wlast, (mBeats == mLen - 1));
        if (wready) begin
          wLog.push_back(wdata);
          wlastLog.push_back(wlast);
          void'(poppedQ.pop_front());
          mBeats++;
        end
      end
      if (bready && bvalid) begin
        mBursts = (mBursts + 1) % 65536;
        mErr    = mErr | (bresp != 2'b00);
        nextOff = mOffset + mLen * BYTES;
        mOffset = (nextOff + BURST_LEN * BYTES > REGION_BYTES) ? 0 : nextOff;
        mBusy   = 0;
        checkDoneNext = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (popNow) fifoDout = fifoQ.pop_front();
    if (fillRandom && fifoQ.size() < BURST_LEN && $urandom_range(0, 2) == 0) fifoQ.push_back(DATA_W'($urandom));
    syncFifo();
  endtask

  task automatic runToIdle(input string name, input int maxCycles);
    int n = 0;
    while (mBusy != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput({name, "_idle"}, busy, 0);
  endtask

  task automatic drainFifo();
    int n = 0;
    enable = 1'b0;
    flush  = 1'b1;
    while ((fifoQ.size() > 0 || mBusy != 0) && n < 300) begin
      tick();
      n++;
    end
    flush = 1'b0;
    tick();
    checkOutput("drainEmpty", fifoEmpty, 1);
    checkOutput("drainIdle", busy, 0);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, held, n;
    vecs[0] = '{1'b1, 1'b0, 4, 1'b1, 3};
    vecs[1] = '{1'b1, 1'b1, 2, 1'b1, 1};
    vecs[2] = '{1'b0, 1'b1, 3, 1'b1, 2};
    vecs[3] = '{1'b0, 1'b0, 4, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 3, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b1, 0, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b1, 6, 1'b1, 3};

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    doReset();
    checkOutput("awsize", awsize, 3'd1);
    checkOutput("awburst", awburst, 2'b01);
    checkOutput("wstrb", wstrb, 2'b11);

    $display("[TB] full burst");
    base = wLog.size();
    n = nPops;
    for (int i = 0; i < 4; i++) pushWord(16'hA0 + 16'(i));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    runToIdle("full", 60);
    checkOutput("fullPops", nPops - n, 4);
    checkOutput("fullAwaddr", awLog[awLog.size()-1], BASE_ADDR);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fullBeat%0d", i), wLog[base+i], 16'hA0 + 16'(i));
      checkOutput($sformatf("fullLast%0d", i), wlastLog[base+i], (i == 3));
    end
    tick();
    checkOutput("fullBurstsDone", burstsDone, 1);
    for (int i = 0; i < 4; i++) pushWord(16'hB0 + 16'(i));
    tick();
    runToIdle("second", 60);
    checkOutput("secondAwaddr", awLog[awLog.size()-1], BASE_ADDR + 8);

    $display("[TB] backpressure");
    n = nPops;
    base = awLog.size();
    for (int i = 0; i < 4; i++) pushWord(16'hC0 + 16'(i));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    for (int i = 0; i < 3; i++) tick();
    awready = 1'b1;
    held = 0;
    n = n + 0;
    for (int i = 0; i < 80 && mBusy != 0; i++) begin
      if (wvalid && mBeats == 1 && held < 2) begin
        wready = 1'b0;
        held++;
      end else begin
        wready = 1'b1;
      end
      tick();
    end
    wready = 1'b1;
    checkOutput("bpIdle", busy, 0);
    checkOutput("bpHeld", held, 2);
    checkOutput("bpPops", nPops - n, 4);
    checkOutput("bpAwCount", awLog.size() - base, 1);

    $display("[TB] flush partial");
    enable = 1'b0;
    tick();
    base = awLog.size();
    pushWord(16'hD0);
    pushWord(16'hD1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("noFlushNoAw", awLog.size() - base, 0);
    flush = 1'b1;
    n = wLog.size();
    tick();
    checkOutput("flushAwlen", awlen, 1);
    runToIdle("flush", 60);
    checkOutput("flushBeats", wLog.size() - n, 2);
    checkOutput("flushLast", {wlastLog[n], wlastLog[n+1]}, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();

    $display("[TB] start decision table");
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].cnt; k++) pushWord(16'h100 * 16'(i) + 16'(k));
      applyStimulus(vecs[i].en, vecs[i].fl, 1'b1, 1'b1, 1'b1, 2'b00);
      tick();
      checkOutput($sformatf("vec%0d_start", i), busy, vecs[i].expStart);
      if (vecs[i].expStart) begin
        checkOutput($sformatf("vec%0d_awlen", i), awlen, vecs[i].expAwlen);
        runToIdle($sformatf("vec%0d", i), 60);
      end else begin
        for (int k = 0; k < 5; k++) tick();
      end
      drainFifo();
    end

    $display("[TB] region wrap");
    doReset();
    base = awLog.size();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) pushWord(16'hE00 + 16'(b * 4 + k));
      tick();
      runToIdle($sformatf("wrap%0d", b), 60);
    end
    checkOutput("wrapAddr0", awLog[base+0], BASE_ADDR + 0);
    checkOutput("wrapAddr1", awLog[base+1], BASE_ADDR + 8);
    checkOutput("wrapAddr2", awLog[base+2], BASE_ADDR + 0);
    checkOutput("wrapAddr3", awLog[base+3], BASE_ADDR + 8);

    $display("[TB] error response");
    doReset();
    for (int k = 0; k < 4; k++) pushWord(16'hF00 + 16'(k));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    tick();
    runToIdle("err1", 60);
    tick();
    checkOutput("errSet", err, 1);
    for (int k = 0; k < 4; k++) pushWord(16'hF10 + 16'(k));
    bresp = 2'b00;
    tick();
    runToIdle("err2", 60);
    tick();
    checkOutput("errStays", err, 1);
    checkOutput("errBursts", burstsDone, 2);
    checkOutput("errIdle", busy, 0);

    $display("[TB] reset mid-burst");
    enable = 1'b0;
    doReset();
    for (int k = 0; k < 4; k++) pushWord(16'h5A0 + 16'(k));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    for (int i = 0; i < 40 && mBeats < 1; i++) tick();
    checkOutput("midBeat1", mBeats, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("midWvalid", wvalid, 0);
    checkOutput("midBusy", busy, 0);
    checkOutput("midAwaddr", awaddr, BASE_ADDR);
    checkOutput("midBursts", burstsDone, 0);
    while (fifoQ.size() < 4) pushWord(16'h5B0 + 16'(fifoQ.size()));
    tick();
    checkOutput("midRestart", busy, 1);
    checkOutput("midRestartAwlen", awlen, 3);
    runToIdle("midRestart", 60);
    drainFifo();

    $display("[TB] randomized traffic");
    randomReady = 1'b1;
    fillRandom = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 16 == 0) begin
        enable = ($urandom_range(0, 2) != 0);
        flush  = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    randomReady = 1'b0;
    fillRandom = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    runToIdle("random", 200);
    drainFifo();
    tick();
    checkOutput("finalBursts", burstsDone, mBursts);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/fifo_axi_drain.md
Name: fifo_axi_drain

Overview:
Sequencer that drains the 16-bit buffering FIFO into memory as AXI4 write bursts. It monitors the FIFO fill level, pops words through the FIFO read strobe, and issues the AW, W and B handshakes. Addresses advance linearly through a circular region. It sits between the FIFO read port and the AXI write master port of the cache/memory side.

Parameters:
DATA_W, 16, FIFO word width and AXI write data width (multiple of 8)
CNT_W, 3, width of fifo_count
BURST_LEN, 4, beats per normal burst (1..256)
ADDR_W, 32, AXI address width
BASE_ADDR, 32'h0000_0000, region start, aligned to BURST_LEN*DATA_W/8
REGION_BYTES, 1024, region size in bytes, multiple of BURST_LEN*DATA_W/8

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset, synchronous, active-low
enable  in  1  allow full-length bursts
flush  in  1  level; allow a partial burst when FIFO is non-empty but below BURST_LEN
fifo_empty  in  1  FIFO empty flag
fifo_count  in  CNT_W  FIFO occupancy
fifo_dout  in  DATA_W  FIFO read data, valid the cycle after fifo_rd
fifo_rd  out  1  FIFO pop strobe, one-cycle pulse
awaddr  out  ADDR_W  burst start address
awlen  out  8  beats-1
awsize  out  3  constant log2(DATA_W/8)
awburst  out  2  constant 2'b01 (INCR)
awvalid / awready  out / in  1  address handshake
wdata  out  DATA_W  write data
wstrb  out  DATA_W/8  constant all ones
wlast  out  1  final beat of the burst
wvalid / wready  out / in  1  data handshake
bresp  in  2  write response
bvalid / bready  in / out  1  response handshake
busy  out  1  state != IDLE
err  out  1  sticky; set on any bresp != 2'b00
bursts_done  out  16  completed-burst counter, wraps at 16'hFFFF

Behaviour:
- Reset (rstn=0 at an edge): state=IDLE. fifo_rd, awvalid, wvalid, wlast, bready, busy and err=0. awaddr=BASE_ADDR, offset=0, bursts_done=0, wdata=0, awlen=0. Reset mid-burst abandons the burst with no completion: valids drop on that edge, and FIFO words already popped are lost.
- States: IDLE, ADDR, POP, LOAD, DATA, RESP.
- IDLE:
  - If enable and fifo_count>=BURST_LEN, latch len=BURST_LEN.
  - Else if flush and !fifo_empty, latch len=fifo_count.
  - On either condition: awlen=len-1, awaddr=BASE_ADDR+offset, go to ADDR. Otherwise stay in IDLE.
  - enable has priority over flush.
- ADDR: awvalid=1, held with stable awaddr/awlen until awready. Handshake edge -> POP, awvalid=0.
- POP:
  - If !fifo_empty: fifo_rd=1 for exactly this cycle, go to LOAD.
  - If fifo_empty (underrun): stay in POP, fifo_rd=0.
- LOAD: wdata<=fifo_dout. wlast<=(beat==len-1). Go to DATA.
- DATA: wvalid=1, with wdata/wlast held stable until wready. Handshake edge: wvalid=0, beat++. If wlast -> RESP, else -> POP. Minimum 3 cycles per beat.
- RESP: bready=1. On the bvalid edge: err|=(bresp!=0), bursts_done++, offset advances, go to IDLE. The response is accepted whatever its bresp value.
- Offset update: next=offset+len*DATA_W/8. If next+BURST_LEN*DATA_W/8 > REGION_BYTES, offset=0 (wrap), else offset=next. A burst never crosses the region end.
- fifo_rd is never asserted while fifo_empty=1 and never outside POP.
- enable/flush changes mid-burst have no effect; they are sampled only in IDLE.

Test Plan:
- Full burst: fifo_count=4, words A0..A3, enable=1, ready signals tied 1 -> one AW with awaddr=0, awlen=3; W beats A0..A3 in order with wlast on A3 only; exactly 4 fifo_rd pulses; bursts_done=1; next awaddr=8.
- Backpressure: awready delayed 3 cycles, wready low 2 cycles on beat 2 -> awaddr/awlen and wdata/wlast stay stable while valid is high; beat data unchanged; no extra fifo_rd.
- Flush partial: fifo_count=2, enable=1, flush=1 -> awlen=1, two beats, wlast on beat 2. With flush=0 and fifo_count=2, no AW is issued for 20 cycles.
- Region wrap: REGION_BYTES=16, four full bursts -> awaddr sequence 0, 8, 0, 8.
- Error response: bresp=2'b10 on burst 1, then OKAY on burst 2 -> err=1 stays set, bursts_done=2, and the controller returns to IDLE both times.
- Reset mid-burst: rstn=0 in DATA after beat 1 -> next edge wvalid=0, busy=0, awaddr=BASE_ADDR, bursts_done=0; a later burst starts cleanly with awlen=3.
